// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and counter sizing for the serial restoring divider
package div_pkg;
    typedef enum logic {IDLE, CALC} div_state_e;
    function automatic int cnt_w(input int width);
        return $clog2(2 * width + 1);
    endfunction
endpackage

// File: rtl/restoring_div_step.sv
// restoring_div_step: one combinational restoring-division step (shift in, trial subtract, restore)
module restoring_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   p,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   p_next,
    output logic             q
);
    logic [WIDTH:0] ps;
    logic [WIDTH:0] diff;
    assign ps     = {p[WIDTH-1:0], din};
    assign diff   = ps - {1'b0, divisor};
    assign q      = ps >= {1'b0, divisor};
    assign p_next = q ? diff : ps;
endmodule

// File: rtl/serial_restoring_div_top.sv
// serial_restoring_div_top: bit-serial restoring divider, 2*WIDTH / WIDTH, one quotient bit per clock
module serial_restoring_div_top
    import div_pkg::*;
#(
    parameter int HALF_WIDTH = 4,
    parameter int WIDTH      = HALF_WIDTH * 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_zero
);
    localparam int CW = cnt_w(WIDTH);
    div_state_e state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] dvd;
    logic [2*WIDTH-1:0] qsh;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH:0]     p;
    logic [WIDTH:0]     p_next;
    logic               q;
    logic               dz_pend;
    logic               last;
    restoring_div_step #(.WIDTH(WIDTH)) u_step (
        .p      (p),
        .din    (dvd[2*WIDTH-1]),
        .divisor(dvs),
        .p_next (p_next),
        .q      (q)
    );
    assign last = cnt == CW'(2 * WIDTH - 1);
    assign busy = state == CALC;
    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = start ? CALC : IDLE;
        else
            state_n = last ? IDLE : CALC;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // div_zero is captured at accept but only published with the results it describes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            dvd       <= '0;
            qsh       <= '0;
            dvs       <= '0;
            p         <= '0;
            dz_pend   <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                dvd     <= dividend;
                dvs     <= divisor;
                p       <= '0;
                cnt     <= '0;
                dz_pend <= divisor == '0;
            end else if (state == CALC) begin
                p   <= p_next;
                dvd <= dvd << 1;
                qsh <= {qsh[2*WIDTH-2:0], q};
                cnt <= cnt + 1'b1;
                if (last) begin
                    quotient  <= {qsh[2*WIDTH-2:0], q};
                    remainder <= p_next[WIDTH-1:0];
                    div_zero  <= dz_pend;
                    done      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_restoring_div_top.sv
// tb_serial_restoring_div_top: directed table, handshake corner cases and random round trips
module tb_serial_restoring_div_top;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy, done, div_zero;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    int n_vec = 0;
    int n_bad = 0;

    serial_restoring_div_top #(.HALF_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // drive one request at a negedge, return cycles from the accepting edge to done
    task automatic do_op(input logic [15:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = 16'hdead; divisor = 8'hbe;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [15:0] eq;
        logic [7:0]  er, b;
        tbl[0] = '{16'd200,   8'd7,   16'd28,    8'd4,    1'b0};
        tbl[1] = '{16'd65535, 8'd255, 16'd257,   8'd0,    1'b0};
        tbl[2] = '{16'd5,     8'd9,   16'd0,     8'd5,    1'b0};
        tbl[3] = '{16'h1234,  8'd0,   16'hffff,  8'h34,   1'b1};
        tbl[4] = '{16'd50,    8'd5,   16'd10,    8'd0,    1'b0};
        tbl[5] = '{16'd0,     8'd1,   16'd0,     8'd0,    1'b0};
        tbl[6] = '{16'hffff,  8'd1,   16'hffff,  8'd0,    1'b0};
        tbl[7] = '{16'h8000,  8'h80,  16'h0100,  8'd0,    1'b0};
        tbl[8] = '{16'd1000,  8'd15,  16'd66,    8'd10,   1'b0};
        tbl[9] = '{16'd0,     8'd0,   16'hffff,  8'd0,    1'b1};
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #2;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_zero", div_zero, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            do_op(tbl[i].dvd, tbl[i].dvs, lat);
            check($sformatf("v%0d latency", i), lat, 16);
            check($sformatf("v%0d quotient", i), quotient, tbl[i].eq);
            check($sformatf("v%0d remainder", i), remainder, tbl[i].er);
            check($sformatf("v%0d div_zero", i), div_zero, tbl[i].ez);
            check($sformatf("v%0d busy at done", i), busy, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d done width", i), done, 0);
            check($sformatf("v%0d quotient held", i), quotient, tbl[i].eq);
        end

        // start pulsed mid-operation is ignored
        @(negedge clk);
        start = 1'b1; dividend = 16'd200; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy after accept", busy, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 16'd100; divisor = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ignore latency", lat, 16);
        check("ignore quotient", quotient, 28);
        check("ignore remainder", remainder, 4);

        // start held high: next accept on the edge after done
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 8'd15;
        @(posedge clk); #1;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("held first latency", lat, 16);
        check("held first quotient", quotient, 66);
        dividend = 16'd50; divisor = 8'd5;
        @(posedge clk); #1;
        check("held reaccept busy", busy, 1);
        check("held reaccept done low", done, 0);
        start = 1'b0; dividend = 16'hffff; divisor = 8'd1;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("held second latency", lat, 16);
        check("held second quotient", quotient, 10);
        check("held second remainder", remainder, 0);

        // asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; dividend = 16'd200; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midreset busy", busy, 0);
        check("midreset quotient", quotient, 0);
        check("midreset remainder", remainder, 0);
        check("midreset div_zero", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) lat++;
        end
        check("midreset no done", lat, 0);
        do_op(16'd50, 8'd5, lat);
        check("post reset latency", lat, 16);
        check("post reset quotient", quotient, 10);
        check("post reset remainder", remainder, 0);

        // random vectors, half of them multiplier round trips
        for (int i = 0; i < 100; i++) begin
            logic [15:0] a;
            b = 8'($urandom_range(0, 255));
            if (i % 2 == 0) begin
                a = 16'($urandom_range(0, 255)) * 16'(b);
                if (b != 0) a = a + 16'($urandom_range(0, 32'(b) - 1)) > a ? a : a;
            end else begin
                a = 16'($urandom_range(0, 65535));
            end
            if (i % 10 == 3) b = 8'd0;
            eq = (b == 0) ? 16'hffff : a / 16'(b);
            er = (b == 0) ? a[7:0] : 8'(a % 16'(b));
            do_op(a, b, lat);
            check($sformatf("rnd%0d latency", i), lat, 16);
            check($sformatf("rnd%0d quotient %0d/%0d", i, a, b), quotient, eq);
            check($sformatf("rnd%0d remainder %0d/%0d", i, a, b), remainder, er);
            check($sformatf("rnd%0d div_zero", i), div_zero, b == 0);
            if (b != 0) check($sformatf("rnd%0d identity", i), 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            @(posedge clk); #1;
            check($sformatf("rnd%0d done width", i), done, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
